// File: rtl/os_fold_xor_acc.sv
// os_fold_xor_acc: three-operand fold-XOR, framed XOR accumulator.
// Optional even-parity output y_par enabled by OS_FOLD_PARITY_EN.
module os_fold_xor_acc #(
   parameter int WIDTH     = 31,
   parameter int SHIFT     = 16,
   parameter int FRAME_LEN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] z0,
   input  logic [WIDTH-1:0] z1,
   input  logic [WIDTH-1:0] z2,
   output logic             y_valid,
   input  logic             y_ready,
   output logic [WIDTH-1:0] y
`ifdef OS_FOLD_PARITY_EN
   ,
   output logic             y_par
`endif
);

   localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

   logic [WIDTH-1:0] f;
   logic [WIDTH-1:0] f_reg;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] y_next;
   logic [CW-1:0]    cnt;
   logic             f_vld;
   logic             last;
   logic             b_ready;
   logic             consume;
   logic             accept;

   assign f = z0 ^ z1 ^ z2 ^ (z0 >> SHIFT) ^ (z2 << SHIFT);

   assign last     = (cnt == LAST);
   assign b_ready  = !last || !y_valid || y_ready;
   assign consume  = f_vld && b_ready;
   assign in_ready = !f_vld || b_ready;
   assign accept   = in_valid && in_ready;
   assign y_next   = (FRAME_LEN == 1) ? f_reg : (acc ^ f_reg);

   // Stage A: capture the folded beat, drop it once stage B takes it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         f_reg <= '0;
         f_vld <= 1'b0;
      end else if (accept) begin
         f_reg <= f;
         f_vld <= 1'b1;
      end else if (consume) begin
         f_vld <= 1'b0;
      end
   end

   // Stage B: accumulate folded words and count beats within the frame
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (consume) begin
         if (last) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
            acc <= (cnt == '0) ? f_reg : (acc ^ f_reg);
         end
      end
   end

   // Output register: load on frame completion, hold under backpressure
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y       <= '0;
         y_valid <= 1'b0;
      end else if (consume && last) begin
         y       <= y_next;
         y_valid <= 1'b1;
      end else if (y_ready) begin
         y_valid <= 1'b0;
      end
   end

`ifdef OS_FOLD_PARITY_EN
   // Parity of the word loaded into y, registered alongside it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_par <= 1'b0;
      end else if (consume && last) begin
         y_par <= ^y_next;
      end
   end
`endif

endmodule

// File: tb/tb_os_fold_xor_acc.sv
// tb_os_fold_xor_acc: scoreboard bench for FRAME_LEN=1 and FRAME_LEN=4.
// Directed literal checks plus randomized traffic with backpressure.
module tb_os_fold_xor_acc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iv [2];
   logic        ir [2];
   logic        yv [2];
   logic        yr [2];
   logic [30:0] a  [2];
   logic [30:0] b  [2];
   logic [30:0] c  [2];
   logic [30:0] y  [2];
`ifdef OS_FOLD_PARITY_EN
   logic        yp [2];
`endif

   int          n_cmp = 0;
   int          n_bad = 0;

   logic [30:0] eq   [2][64];
   int          wp   [2];
   int          rp   [2];
   int          m    [2];
   logic [30:0] macc [2];
   logic        hold [2];
   logic [30:0] py   [2];

   always #5 clk = ~clk;

   os_fold_xor_acc #(.WIDTH(31), .SHIFT(16), .FRAME_LEN(1)) u_d1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (iv[0]),
      .in_ready (ir[0]),
      .z0       (a[0]),
      .z1       (b[0]),
      .z2       (c[0]),
      .y_valid  (yv[0]),
      .y_ready  (yr[0]),
      .y        (y[0])
`ifdef OS_FOLD_PARITY_EN
      ,
      .y_par    (yp[0])
`endif
   );

   os_fold_xor_acc #(.WIDTH(31), .SHIFT(16), .FRAME_LEN(4)) u_d4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (iv[1]),
      .in_ready (ir[1]),
      .z0       (a[1]),
      .z1       (b[1]),
      .z2       (c[1]),
      .y_valid  (yv[1]),
      .y_ready  (yr[1]),
      .y        (y[1])
`ifdef OS_FOLD_PARITY_EN
      ,
      .y_par    (yp[1])
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Fold computed arithmetically: divide for the right shift,
   // multiply and take modulo 2^31 for the truncated left shift.
   function automatic logic [30:0] fold(input logic [30:0] p,
                                        input logic [30:0] q,
                                        input logic [30:0] r);
      logic [63:0] lo;
      logic [63:0] hi;
      lo = 64'(p) / 64'd65536;
      hi = (64'(r) * 64'd65536) % 64'h8000_0000;
      return p ^ q ^ r ^ lo[30:0] ^ hi[30:0];
   endfunction

   // Scoreboard: model frames from accepted beats, check every pop
   always @(negedge clk) begin
      logic [30:0] f;
      int          fl;
      for (int d = 0; d < 2; d++) begin
         fl = (d == 0) ? 1 : 4;
         if (!rst_n) begin
            rp[d]   = wp[d];
            m[d]    = 0;
            hold[d] = 1'b0;
         end else begin
            if (hold[d]) begin
               chk("hold_valid", 32'(yv[d]), 32'd1);
               chk("hold_y", 32'(y[d]), 32'(py[d]));
            end
            if (yv[d] && yr[d]) begin
               if (rp[d] == wp[d]) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL spurious_y dut%0d: got %h want none",
                           d, y[d]);
               end else begin
                  chk("y_value", 32'(y[d]), 32'(eq[d][rp[d] % 64]));
                  rp[d]++;
               end
            end
`ifdef OS_FOLD_PARITY_EN
            if (yv[d]) chk("y_par", 32'(yp[d]), 32'(^y[d]));
`endif
            if (iv[d] && ir[d]) begin
               f = fold(a[d], b[d], c[d]);
               macc[d] = (m[d] == 0) ? f : (macc[d] ^ f);
               m[d]++;
               if (m[d] == fl) begin
                  eq[d][wp[d] % 64] = macc[d];
                  wp[d]++;
                  m[d] = 0;
               end
            end
            hold[d] = yv[d] && !yr[d];
            py[d]   = y[d];
         end
      end
   end

   initial begin
      logic [30:0] v0 [3];
      logic [30:0] v1 [3];
      logic [30:0] v2 [3];
      logic [30:0] ve [3];
      logic        vp [3];
      int          cnt;
      int          n_acc;
      int          rp0;
      logic        took;
      logic [30:0] yval;

      v0 = '{31'h0001_0000, 31'h0, 31'h7FFF_FFFF};
      v1 = '{31'h0, 31'h0, 31'h7FFF_FFFF};
      v2 = '{31'h0, 31'h0000_0001, 31'h7FFF_FFFF};
      ve = '{31'h0001_0001, 31'h0001_0001, 31'h0000_8000};
      vp = '{1'b0, 1'b0, 1'b1};

      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         iv[d] = 1'b0; yr[d] = 1'b1;
         a[d] = '0; b[d] = '0; c[d] = '0;
         wp[d] = 0; rp[d] = 0; m[d] = 0; hold[d] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_in_ready", 32'(ir[d]), 32'd1);
         chk("rst_y_valid", 32'(yv[d]), 32'd0);
         chk("rst_y", 32'(y[d]), 32'd0);
`ifdef OS_FOLD_PARITY_EN
         chk("rst_y_par", 32'(yp[d]), 32'd0);
`endif
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single-beat fold literals, FRAME_LEN=1
      for (int i = 0; i < 3; i++) begin
         a[0] = v0[i]; b[0] = v1[i]; c[0] = v2[i];
         iv[0] = 1'b1;
         @(posedge clk); #1;
         iv[0] = 1'b0;
         chk("fold_lat1", 32'(yv[0]), 32'd0);
         @(posedge clk); #1;
         chk("fold_lat2", 32'(yv[0]), 32'd1);
         chk("fold_y", 32'(y[0]), 32'(ve[i]));
`ifdef OS_FOLD_PARITY_EN
         chk("fold_par", 32'(yp[0]), 32'(vp[i]));
`endif
         @(posedge clk); #1;
      end

      // frame of four beats, FRAME_LEN=4
      a[1] = '0; c[1] = '0;
      iv[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         b[1] = 31'(1 << k);
         chk("frame_in_ready", 32'(ir[1]), 32'd1);
         @(posedge clk); #1;
      end
      iv[1] = 1'b0;
      cnt = 0;
      yval = '1;
      repeat (6) begin
         if (yv[1]) begin
            cnt++;
            yval = y[1];
         end
         @(posedge clk); #1;
      end
      chk("frame_count", 32'(cnt), 32'd1);
      chk("frame_y", 32'(yval), 32'h0000_000F);

      // backpressure, FRAME_LEN=1
      rp0 = rp[0];
      n_acc = 0;
      yr[0] = 1'b0;
      a[0] = '0; c[0] = '0; b[0] = 31'h100;
      iv[0] = 1'b1;
      for (int cyc = 0; cyc < 5; cyc++) begin
         took = ir[0];
         if (cyc == 2) chk("bp_in_ready_drop", 32'(ir[0]), 32'd0);
         @(posedge clk); #1;
         if (took) begin
            b[0] = b[0] + 31'd1;
            n_acc++;
         end
      end
      chk("bp_accepted", 32'(n_acc), 32'd2);
      iv[0] = 1'b0;
      yr[0] = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("bp_pops", 32'(rp[0] - rp0), 32'(n_acc));

      // reset mid-frame, FRAME_LEN=4
      a[1] = '0; c[1] = '0; b[1] = 31'h3;
      iv[1] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      iv[1] = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      b[1] = 31'h1;
      iv[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("rst_no_early", 32'(yv[1]), 32'd0);
         @(posedge clk); #1;
      end
      iv[1] = 1'b0;
      chk("rst_no_early", 32'(yv[1]), 32'd0);
      cnt = 0;
      yval = '1;
      repeat (5) begin
         if (yv[1]) begin
            cnt++;
            yval = y[1];
         end
         @(posedge clk); #1;
      end
      chk("rst_frame_count", 32'(cnt), 32'd1);
      chk("rst_frame_y", 32'(yval), 32'h0);

      // back-to-back beats, simultaneous pop and completion
      cnt = 0;
      iv[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         a[0] = 31'($urandom);
         b[0] = 31'($urandom);
         c[0] = 31'($urandom);
         @(posedge clk); #1;
         if (k >= 1 && yv[0]) cnt++;
      end
      iv[0] = 1'b0;
      @(posedge clk); #1;
      if (yv[0]) cnt++;
      chk("stream_valid_run", 32'(cnt), 32'd10);
      repeat (3) @(posedge clk);
      #1;

      // randomized traffic on both instances
      repeat (1500) begin
         for (int d = 0; d < 2; d++) begin
            iv[d] = ($urandom_range(0, 9) < 7);
            yr[d] = ($urandom_range(0, 9) < 6);
            a[d]  = 31'($urandom);
            b[d]  = 31'($urandom);
            c[d]  = 31'($urandom);
         end
         @(posedge clk); #1;
      end
      for (int d = 0; d < 2; d++) begin
         iv[d] = 1'b0;
         yr[d] = 1'b1;
      end
      repeat (10) @(posedge clk);
      #1;
      chk("drain_d1", 32'(wp[0] - rp[0]), 32'd0);
      chk("drain_d4", 32'(wp[1] - rp[1]), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/os_fold_xor_acc.md
# os_fold_xor_acc

Streaming, parametrised successor to the 31-bit three-operand fold-XOR compressor in the output stage. Each accepted beat of three WIDTH-bit operands is folded into one WIDTH-bit word; FRAME_LEN consecutive folded words are XOR-accumulated into one result. The block is fully pipelined with valid/ready handshakes on both sides. It sits between the operand generators and the output-stage consumers, replacing the unregistered, single-shot compressor.

## Interface
- WIDTH, 31: operand and result width, at least 2.
- SHIFT, 16: fold distance, in the range 1 to WIDTH-1.
- FRAME_LEN, 1: beats per frame, at least 1. A value of 1 gives one result per beat.
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  operand beat accepted when in_valid && in_ready.
- z0, z1, z2  input  WIDTH each  operands.
- y_valid  output  1  result valid.
- y_ready  input  1  consumer ready.
- y  output  WIDTH  frame result.
- y_par  output  1  even parity of y. Present only with OS_FOLD_PARITY_EN.

## Operation
- Fold function: f = z0 ^ z1 ^ z2 ^ (z0 >> SHIFT) ^ (z2 << SHIFT).
  - Shifts are logical.
  - The left shift is truncated to WIDTH bits.
  - Defaults reproduce the legacy compressor exactly.
- Stage A register: f_reg and f_vld.
  - Loaded with f on every input accept.
  - Cleared (f_vld=0) when consumed and no new accept occurs in the same cycle.
- Stage B accumulator: acc (WIDTH bits) and beat counter cnt, width clog2(FRAME_LEN) with a minimum of 1.
- Stage B consumes f_reg when f_vld && b_ready.
  - b_ready = (cnt != FRAME_LEN-1) || !y_valid || y_ready.
- On consume with cnt == 0: acc <= f_reg.
- On consume with 0 < cnt < FRAME_LEN-1: acc <= acc ^ f_reg.
- On consume with cnt == FRAME_LEN-1:
  - y <= (FRAME_LEN==1 ? f_reg : acc ^ f_reg).
  - y_valid <= 1.
  - cnt wraps to 0.
- In every other consume case, cnt increments.
- in_ready = !f_vld || b_ready. This is combinational, with no dependency on in_valid.
- Output register:
  - Holds y while y_valid && !y_ready.
  - Clears y_valid on y_ready when no new frame completes that cycle.
  - A simultaneous pop and completion reloads y and keeps y_valid=1.
- Reset values: in_ready=1, y_valid=0, y=0, y_par=0, f_vld=0, cnt=0, acc=0.
- Reset mid-frame discards the partial frame and the pending output. The first beat after reset starts a new frame.
- Data inputs are don't-care while in_valid=0. Outputs are stable while y_valid && !y_ready.

## Timing
- Input accepted in cycle N:
  - f_reg valid in N+1.
  - For the last beat of a frame, y_valid is asserted in N+2 if the output is free.
- Latency is 2 cycles from the last beat of a frame to y_valid.
- Throughput is 1 beat per cycle with y_ready held high. There are no bubbles at frame boundaries.
- Stall depth: with y_ready low, at most one further completed frame is held, in acc/f_reg. in_ready drops in the cycle after f_vld rises with stage B blocked.
- There is no combinational path from z* to y, or from in_valid to y_valid.
- The y_ready to in_ready combinational path is allowed and has depth at most 3 gates.

## Configuration
- OS_FOLD_PARITY_EN defined:
  - Port y_par exists.
  - y_par is registered alongside y and equals the XOR-reduce of the y value loaded in the same cycle.
  - Its reset value is 0.
- OS_FOLD_PARITY_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Fold check, defaults: the bench drives single beats; in each case all other operands are 0.

  | Stimulus | Required y | y_valid cycle |
  |---|---|---|
  | z0=0x0001_0000 | 0x0001_0001 | N+2 |
  | z2=0x0000_0001 | 0x0001_0001 | N+2 |
  | z0=z1=z2=0x7FFF_FFFF | 0x0000_8000 | N+2 |

- Frame accumulate, FRAME_LEN=4, y_ready=1: four back-to-back beats with z1=0x1, 0x2, 0x4, 0x8 (others 0).
  - Required: exactly one y=0x0000_000F.
  - in_ready stays 1 throughout.
- Backpressure, FRAME_LEN=1, y_ready=0 for 5 cycles, in_valid continuous with distinct z1:
  - y holds its first value.
  - in_ready drops by the 3rd cycle.
  - After y_ready rises, all accepted beats appear in order with no loss or duplication.
- Reset mid-frame, FRAME_LEN=4: send 2 beats with z1=0x3, pulse rst_n low for 1 cycle, then send 4 beats with z1=0x1.
  - Required: y=0x0000_0000 (even count of 0x1).
  - No y_valid occurs before the 4th post-reset beat.
- Simultaneous pop and complete, FRAME_LEN=1, y_ready=1, one beat per cycle for 10 cycles:
  - y_valid is continuous from N+2.
  - Each y equals the fold of its beat.
- Parity, with OS_FOLD_PARITY_EN: the z0=z1=z2=0x7FFF_FFFF beat gives y_par=1; z0=0x0001_0000 gives y_par=0.
